uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmit line between two byte producers. Arbitrates round-robin, accepts one byte per frame over a valid/ready handshake, and serializes it as 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit). Bit timing comes from an internal per-bit cycle counter. The default divisor matches the team's existing baud generator, which has a period of 434 clk. The block sits between the on-chip message sources and the `txd` pad.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit. Legal range is 2..65535.
- `clk`  in  1  clock. All logic is on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  2  bit i: requester i holds a byte to send.
- `req_data0`  in  8  byte from requester 0.
- `req_data1`  in  8  byte from requester 1.
- `req_ready`  out  2  bit i: byte i accepted this cycle. Transfer happens when `valid[i] & ready[i]`.
- `txd`  out  1  serial output. Idle level is 1.
- `busy`  out  1  high while a frame is on the line (START, DATA or STOP).
- `grant_id`  out  1  requester whose byte is in flight or was last sent.

## Operation
- The FSM has four states: IDLE, START, DATA, STOP.
- **IDLE, arbitration:**
  - If any `req_valid` bit is set, pick a winner.
  - Exactly one valid: that requester wins.
  - Both valid: the requester that is not `last_grant` wins.
  - `req_ready[winner]` = 1 combinationally in that cycle only.
  - On that edge: capture the winner's data into `shreg[7:0]`, set `grant_id` and `last_grant` to the winner, clear `bit_cnt` and `baud_cnt`, and go to START.
- **START:** `txd` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:**
  - `txd` = `shreg[0]`.
  - At the end of each bit time, shift `shreg` right and increment `bit_cnt`.
  - After bit 7 (`bit_cnt` = 7 at the bit end), go to STOP.
- **STOP:** `txd` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- **Per-bit counter:**
  - `baud_cnt` width is `$clog2(CLKS_PER_BIT)`.
  - It counts 0..`CLKS_PER_BIT`-1. The bit ends when `baud_cnt` = `CLKS_PER_BIT`-1, and the counter then wraps to 0.
- **Handshake rules:**
  - Once raised, `req_valid` and the request's data stay stable until the matching ready.
  - `req_ready` is 0 in every non-IDLE state.
  - Changing `req_data*` after acceptance has no effect on the frame in flight.
- **Reset values:** state = IDLE, `txd` = 1, `busy` = 0, `grant_id` = 0, `last_grant` = 1 (requester 0 wins the first tie), all counters = 0, `shreg` = 0.
- **Reset mid-frame:**
  - The frame is abandoned and `txd` goes to 1 asynchronously.
  - The byte is not retransmitted; the requester already saw ready.

## Timing
- `txd`, `busy` and `grant_id` are registered. `req_ready` is combinational from state and `req_valid`.
- Acceptance at edge T: `txd` falls to 0 after edge T, and `busy` = 1 from T+1.
- One frame lasts 10·`CLKS_PER_BIT` cycles with `busy` = 1.
- Back-to-back frames: one IDLE cycle (`txd` = 1, `busy` = 0) between the STOP end and the next acceptance. The line therefore sees `CLKS_PER_BIT`+1 high cycles between frames.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…

## Structure
- **Package `uart_pkg`:**
  - state enum `uart_tx_state_t` (IDLE, START, DATA, STOP)
  - `UART_CLKS_PER_BIT_DEFAULT` = 434
  - `UART_DATA_BITS` = 8
  - `UART_FRAME_BITS` = 10
- **Sub-module `uart_tx_frame`:** the serializer. It holds the FSM, `baud_cnt`, `bit_cnt` and `shreg`, and exposes a start/data/idle interface.
- The top level holds the round-robin arbiter, `last_grant`, and the data mux.

## Test plan
- **Reset:** hold `resetn` = 0 with both requests valid → `txd` = 1, `busy` = 0, `req_ready` = 00, `grant_id` = 0.
- **Single byte:** `CLKS_PER_BIT` = 4, req0 sends 0xA5 → `req_ready` = 01 for 1 cycle; `txd` = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles; `busy` high for 40 cycles; `grant_id` = 0.
- **Tie after reset:** req0 = 0x11 and req1 = 0x22, both valid → 0x11 is sent first, then 0x22 is accepted in the IDLE cycle after the stop bit. If both are valid again, req0 wins the third grant.
- **Continuous requester:** req1 continuously valid → consecutive frames separated by exactly 5 high cycles (stop + 1 IDLE); `req_ready[1]` pulses once per 41 cycles.
- **Reset mid-frame:** assert `resetn` low during DATA bit 3 → `txd` = 1 immediately and `busy` = 0. After release, a pending req1 with req0 idle is sent in full from a fresh start bit.
- **Data stability:** change `req_data0` to 0xFF one cycle after acceptance of 0x3C → the frame on `txd` still carries 0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 434;
  localparam int UART_DATA_BITS            = 8;
  localparam int UART_FRAME_BITS           = 10;

endpackage

// File: rtl/uart_tx_frame.sv
// 8N1 serializer: takes one byte on start_i while idle and shifts it out LSB first
// between a start bit and a stop bit, each bit lasting CLKS_PER_BIT cycles.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start_i,
  input  logic [UART_DATA_BITS-1:0] data_i,
  output logic                      idle_o,
  output logic                      txd_o,
  output logic                      busy_o
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]         baud_cnt_q, baud_cnt_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      txd_q, txd_d;
  logic                      busy_q, busy_d;
  logic                      bit_end_s;

  assign bit_end_s = (baud_cnt_q == BAUD_LAST);

  // Next-state, counters and shift register.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shreg_d    = data_i;
          bit_cnt_d  = 3'd0;
          baud_cnt_d = '0;
          state_d    = START;
        end else begin
          state_d = IDLE;
        end
      end
      START, STOP: begin
        if (bit_end_s) begin
          baud_cnt_d = '0;
          state_d    = (state_q == START) ? DATA : IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_cnt_d = '0;
          shreg_d    = {1'b0, shreg_q[UART_DATA_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
        bit_cnt_d  = 3'd0;
      end
    endcase
  end

  // Line level follows the next state so txd and busy are registered yet aligned with it.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  // State and output registers; reset returns the line to idle-high at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
    end
  end

  assign idle_o = (state_q == IDLE);
  assign txd_o  = txd_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a single 8N1 transmitter.
// A byte is accepted only while the serializer is idle; ties go to the requester not served last.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic       txd,
  output logic       busy,
  output logic       grant_id
);

  logic       idle_s;
  logic       win_s;
  logic       start_s;
  logic [1:0] ready_s;
  logic [7:0] data_s;
  logic       last_grant_q, last_grant_d;
  logic       grant_id_q, grant_id_d;

  // Round-robin winner selection and handshake.
  always_comb begin
    win_s   = 1'b0;
    ready_s = 2'b00;
    if (req_valid == 2'b11) begin
      win_s = ~last_grant_q;
    end else if (req_valid[1]) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    // Gating with resetn keeps ready low while the block is held in reset.
    start_s = idle_s & (|req_valid) & resetn;
    if (start_s) begin
      ready_s = win_s ? 2'b10 : 2'b01;
    end else begin
      ready_s = 2'b00;
    end
    data_s       = win_s ? req_data1 : req_data0;
    last_grant_d = start_s ? win_s : last_grant_q;
    grant_id_d   = start_s ? win_s : grant_id_q;
  end

  // Grant history; last_grant starts at 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
    end
  end

  uart_tx_frame #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_frame (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (start_s),
    .data_i  (data_s),
    .idle_o  (idle_s),
    .txd_o   (txd),
    .busy_o  (busy)
  );

  assign req_ready = ready_s;
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short bit time; every frame is checked cycle by cycle.
module tb_uart_tx_arbiter;

  localparam int CPB = 4;

  logic       clk;
  logic       resetn;
  logic [1:0] req_valid;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_ready;
  logic       txd;
  logic       busy;
  logic       grant_id;

  int n_vec  = 0;
  int n_miss = 0;

  uart_tx_arbiter #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .txd       (txd),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called in an IDLE cycle after inputs are set: {ready,busy,txd}.
  task automatic idle_check(input string tag, input logic [1:0] exp_ready);
    #1;
    check_vec(tag, {req_ready, busy, txd}, {exp_ready, 1'b0, 1'b1});
  endtask

  // Called just before the accepting edge; checks the whole 10-bit frame.
  task automatic check_frame(input logic [7:0] exp_byte, input logic exp_gid,
                             input logic [1:0] drop, input logic [7:0] post_d0,
                             input string tag);
    logic eb;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_vec({tag, " gid"}, grant_id, exp_gid);
        req_valid = req_valid & ~drop;
        req_data0 = post_d0;
      end
      if (c < CPB) eb = 1'b0;
      else if (c < 9 * CPB) eb = exp_byte[c / CPB - 1];
      else eb = 1'b1;
      check_vec($sformatf("%s c%0d rdy_busy_txd", tag, c), {req_ready, busy, txd},
                {2'b00, 1'b1, eb});
    end
  endtask

  initial begin
    resetn    = 1'b0;
    req_valid = 2'b11;
    req_data0 = 8'h00;
    req_data1 = 8'h00;
    repeat (2) @(negedge clk);
    check_vec("rst txd", txd, 1'b1);
    check_vec("rst busy", busy, 1'b0);
    check_vec("rst ready", req_ready, 2'b00);
    check_vec("rst gid", grant_id, 1'b0);
    req_valid = 2'b00;
    resetn    = 1'b1;

    // single byte
    @(negedge clk);
    req_data0 = 8'hA5;
    req_valid = 2'b01;
    idle_check("single accept", 2'b01);
    check_frame(8'hA5, 1'b0, 2'b01, 8'hA5, "single");
    @(negedge clk);
    idle_check("single idle", 2'b00);

    // tie after reset, then alternation
    resetn = 1'b0;
    @(negedge clk);
    resetn    = 1'b1;
    req_data0 = 8'h11;
    req_data1 = 8'h22;
    req_valid = 2'b11;
    idle_check("tie1 accept", 2'b01);
    check_frame(8'h11, 1'b0, 2'b01, 8'h11, "tie1");
    @(negedge clk);
    idle_check("tie2 accept", 2'b10);
    check_frame(8'h22, 1'b1, 2'b10, 8'h11, "tie2");
    @(negedge clk);
    req_data0 = 8'h33;
    req_data1 = 8'h44;
    req_valid = 2'b11;
    idle_check("tie3 accept", 2'b01);
    check_frame(8'h33, 1'b0, 2'b01, 8'h33, "tie3");
    @(negedge clk);
    idle_check("tie4 accept", 2'b10);
    check_frame(8'h44, 1'b1, 2'b10, 8'h33, "tie4");

    // continuous requester 1
    @(negedge clk);
    req_data1 = 8'h5A;
    req_valid = 2'b10;
    idle_check("cont1 accept", 2'b10);
    check_frame(8'h5A, 1'b1, 2'b00, 8'h33, "cont1");
    @(negedge clk);
    req_data1 = 8'h69;
    idle_check("cont2 accept", 2'b10);
    check_frame(8'h69, 1'b1, 2'b00, 8'h33, "cont2");
    @(negedge clk);
    req_valid = 2'b00;
    idle_check("cont end", 2'b00);

    // reset during DATA bit 3
    @(negedge clk);
    req_data0 = 8'hC3;
    req_valid = 2'b01;
    idle_check("mid accept", 2'b01);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = 2'b00;
    end
    check_vec("mid bit3 txd", {busy, txd}, 2'b10);
    #2;
    resetn    = 1'b0;
    req_data1 = 8'h96;
    req_valid = 2'b10;
    #1;
    check_vec("mid rst line", {req_ready, busy, txd}, {2'b00, 1'b0, 1'b1});
    @(negedge clk);
    resetn = 1'b1;
    idle_check("resume accept", 2'b10);
    check_frame(8'h96, 1'b1, 2'b10, 8'hC3, "resume");
    @(negedge clk);
    idle_check("resume idle", 2'b00);

    // data changed right after acceptance
    @(negedge clk);
    req_data0 = 8'h3C;
    req_valid = 2'b01;
    idle_check("stab accept", 2'b01);
    check_frame(8'h3C, 1'b0, 2'b01, 8'hFF, "stab");
    @(negedge clk);
    idle_check("stab idle", 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
